// File: rtl/seg2hex_scan.sv
// seg2hex_scan
// Watches a multiplexed 4-digit, 7-segment display bus and recovers the hex
// value shown on each digit slot.
//
// The segment and anode lines are synchronized first. A sample must stay
// unchanged for STABLE_CYCLES consecutive clocks before its digit is captured.
// Captures from all four slots are collected into a frame.
//
// Ports
//   clk          system clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   seg[6:0]     segment lines, active-low, seg[0]=a .. seg[6]=g
//   an[3:0]      anode selects, active-low, an[i]=0 selects slot i
//   digits[15:0] captured nibbles, slot i in digits[4i+3:4i]
//   digit_err    bit i set when the last capture of slot i was not a hex glyph
//   frame_valid  one-cycle pulse once every slot has been captured since the
//                previous pulse
//   state        FSM state (00 IDLE, 01 SETTLE, 10 HELD), for debug
module seg2hex_scan #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        HELD   = 2'b10
    } state_t;

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [6:0]  seg_meta_q, seg_sync_q;
    logic [3:0]  an_meta_q, an_sync_q;
    logic [10:0] prev_q;
    logic [7:0]  cnt_q;
    logic [3:0]  mask_q;
    logic [15:0] digits_q;
    logic [3:0]  err_q;
    logic        fv_q;
    state_t      state_q;

    logic [10:0] sample_d;
    logic [3:0]  an_low;
    logic        selected;
    logic        same;
    logic [4:0]  dec;
    logic [1:0]  slot_idx;
    logic [3:0]  mask_d;
    logic        capture;

    // Returns {recognized, nibble}. Unrecognized patterns return nibble 0.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b1000000: decode_seg = {1'b1, 4'h0};
            7'b1111001: decode_seg = {1'b1, 4'h1};
            7'b0100100: decode_seg = {1'b1, 4'h2};
            7'b0110000: decode_seg = {1'b1, 4'h3};
            7'b0011001: decode_seg = {1'b1, 4'h4};
            7'b0010010: decode_seg = {1'b1, 4'h5};
            7'b0000010: decode_seg = {1'b1, 4'h6};
            7'b1111000: decode_seg = {1'b1, 4'h7};
            7'b0000000: decode_seg = {1'b1, 4'h8};
            7'b0010000: decode_seg = {1'b1, 4'h9};
            7'b0001000: decode_seg = {1'b1, 4'hA};
            7'b0000011: decode_seg = {1'b1, 4'hB};
            7'b1000110: decode_seg = {1'b1, 4'hC};
            7'b0100001: decode_seg = {1'b1, 4'hD};
            7'b0000110: decode_seg = {1'b1, 4'hE};
            7'b0001110: decode_seg = {1'b1, 4'hF};
            default:    decode_seg = 5'b0_0000;
        endcase
    endfunction

    always_comb begin
        sample_d = {an_sync_q, seg_sync_q};
        an_low   = ~an_sync_q;
        // Exactly one anode is low when the vector is non-zero and a power of two.
        selected = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
        same     = (sample_d == prev_q);
        dec      = decode_seg(seg_sync_q);
        slot_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (an_low[i]) begin
                slot_idx = 2'(i);
            end
        end
        mask_d  = mask_q | an_low;
        // The sample that brings the run count to STABLE_CYCLES is the one that
        // captures, so capture fires one count early.
        capture = (state_q == SETTLE) && selected && same &&
                  ((cnt_q + 8'd1) >= STABLE_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_q <= 7'd0;
            seg_sync_q <= 7'd0;
            an_meta_q  <= 4'd0;
            an_sync_q  <= 4'd0;
            prev_q     <= 11'd0;
            cnt_q      <= 8'd0;
            mask_q     <= 4'd0;
            digits_q   <= 16'h0000;
            err_q      <= 4'b0000;
            fv_q       <= 1'b0;
            state_q    <= IDLE;
        end else begin
            seg_meta_q <= seg;
            seg_sync_q <= seg_meta_q;
            an_meta_q  <= an;
            an_sync_q  <= an_meta_q;
            prev_q     <= sample_d;
            fv_q       <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (selected) begin
                        state_q <= SETTLE;
                        cnt_q   <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (!selected) begin
                        state_q <= IDLE;
                    end else if (!same) begin
                        cnt_q <= 8'd1;
                    end else if (capture) begin
                        state_q <= HELD;
                        cnt_q   <= STABLE_LIM;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                HELD: begin
                    if (!selected) begin
                        state_q <= IDLE;
                    end else if (!same) begin
                        state_q <= SETTLE;
                        cnt_q   <= 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (capture) begin
                digits_q[{slot_idx, 2'b00} +: 4] <= dec[3:0];
                err_q[slot_idx]                  <= ~dec[4];
                // The completing capture pulses the frame flag on the same
                // edge that writes the last nibble, and starts a new frame.
                if (mask_d == 4'hF) begin
                    fv_q   <= 1'b1;
                    mask_q <= 4'd0;
                end else begin
                    mask_q <= mask_d;
                end
            end
        end
    end

    assign digits      = digits_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;
    assign state       = state_q;

endmodule

// File: tb/tb_seg2hex_scan.sv
// Testbench for seg2hex_scan. A run-length based model of the display
// scanner is checked against the DUT on every clock, alongside directed
// scenarios with hand-computed expectations and a randomized phase.
module tb_seg2hex_scan;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an = 4'hF;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic [1:0]  state;

    seg2hex_scan #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .state       (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;
    int fv_base;

    // Glyph table, index = hex value, bits written as seg[6:0].
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model state: the synchronizer is a plain two-deep delay, and capture is
    // decided by the length of the current run of identical selected samples.
    logic [10:0] m_d1 = '0, m_d2 = '0, m_prev = '0;
    int          m_run = 0;
    logic [15:0] m_digits = '0;
    logic [3:0]  m_err = '0;
    logic [3:0]  m_mask = '0;
    logic        m_fv = 1'b0;
    logic [1:0]  m_state = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (glyph[i] == s) return i;
        end
        return -1;
    endfunction

    // Behavioural model.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_d1 = '0; m_d2 = '0; m_prev = '0; m_run = 0;
                m_digits = '0; m_err = '0; m_mask = '0; m_fv = 1'b0; m_state = 2'b00;
            end else begin
                logic [10:0] smp;
                logic        sel;
                smp  = m_d2;
                m_d2 = m_d1;
                m_d1 = {an, seg};
                sel  = ($countones(~smp[10:7]) == 1);
                if (sel && m_run > 0 && smp == m_prev)
                    m_run = (m_run > S) ? m_run : m_run + 1;
                else
                    m_run = sel ? 1 : 0;
                m_prev = smp;
                m_fv   = 1'b0;
                if (m_run == S) begin
                    int slot;
                    int v;
                    slot = 0;
                    for (int i = 0; i < 4; i++) if (!smp[7 + i]) slot = i;
                    v = lookup(smp[6:0]);
                    m_digits[slot*4 +: 4] = (v < 0) ? 4'h0 : 4'(v);
                    m_err[slot] = (v < 0);
                    m_mask[slot] = 1'b1;
                    if (m_mask == 4'hF) begin
                        m_fv = 1'b1;
                        m_mask = 4'h0;
                    end
                end
                m_state = (m_run == 0) ? 2'b00 : (m_run < S) ? 2'b01 : 2'b10;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("digits", 32'(digits), 32'(m_digits));
            chk("digit_err", 32'(digit_err), 32'(m_err));
            chk("frame_valid", 32'(frame_valid), 32'(m_fv));
            chk("state", 32'(state), 32'(m_state));
            if (frame_valid === 1'b1) fv_count++;
        end
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
        $display("hold an=%b seg=%b cycles=%0d -> digits=%h err=%b", a, s, n, digits, digit_err);
    endtask

    task automatic blank(input int n);
        hold(4'hF, 7'h7F, n);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_err", 32'(digit_err), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_state", 32'(state), 32'h0);
        rst_n = 1'b1;
        blank(3);

        // Single digit with latency check: visible after edge S+2.
        an = 4'b1110; seg = 7'b0100100;
        repeat (S + 1) @(negedge clk);
        chk("lat_before", 32'(digits[3:0]), 32'h0);
        @(negedge clk);
        chk("lat_after", 32'(digits[3:0]), 32'h2);
        chk("lat_err", 32'(digit_err[0]), 32'h0);
        repeat (4) @(negedge clk);
        $display("single digit: digits=%h", digits);
        blank(3);

        // Full scan of four slots, one frame.
        fv_base = fv_count;
        hold(4'b1110, 7'b1111001, 8); blank(2);
        hold(4'b1101, 7'b0001000, 8); blank(2);
        hold(4'b1011, 7'b0000011, 8); blank(2);
        hold(4'b0111, 7'b0001110, 8); blank(2);
        blank(2);
        chk("scan_digits", 32'(digits), 32'hFBA1);
        chk("scan_frames", 32'(fv_count - fv_base), 32'd1);

        // Toggling segments never settle.
        fv_base = fv_count;
        for (int i = 0; i < 10; i++) hold(4'b1101, (i % 2 == 0) ? 7'b0000000 : 7'b0010000, 2);
        chk("toggle_state", 32'(state), 32'h1);
        blank(3);
        chk("toggle_digits", 32'(digits), 32'hFBA1);
        chk("toggle_frames", 32'(fv_count - fv_base), 32'd0);

        // Unrecognized glyph then valid glyph on slot 2.
        hold(4'b1011, 7'b1111111, 8);
        chk("bad_nib", 32'(digits[11:8]), 32'h0);
        chk("bad_err", 32'(digit_err[2]), 32'h1);
        hold(4'b1011, 7'b0110000, 8);
        chk("good_nib", 32'(digits[11:8]), 32'h3);
        chk("good_err", 32'(digit_err[2]), 32'h0);
        blank(3);

        // Two anodes low is blank.
        hold(4'b0011, 7'b1000000, 10);
        chk("multi_state", 32'(state), 32'h0);
        chk("multi_digits", 32'(digits), 32'hF3A1);
        blank(3);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            logic [3:0] a;
            logic [6:0] s;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 7) a = 4'hF;
            else             a = 4'($urandom);
            if ($urandom_range(0, 4) != 0) s = glyph[$urandom_range(0, 15)];
            else                           s = 7'($urandom);
            an = a; seg = s;
            repeat ($urandom_range(1, 9)) @(negedge clk);
        end
        blank(4);

        // Reset in the middle of a frame.
        hold(4'b1110, 7'b1000000, 8); blank(2);
        hold(4'b1101, 7'b0010010, 8); blank(2);
        an = 4'b1011; seg = 7'b1000110;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        an = 4'hF; seg = 7'h7F;
        #1;
        chk("mid_rst_digits", 32'(digits), 32'h0);
        chk("mid_rst_err", 32'(digit_err), 32'h0);
        chk("mid_rst_fv", 32'(frame_valid), 32'h0);
        chk("mid_rst_state", 32'(state), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fv_base = fv_count;
        blank(3);
        hold(4'b1110, 7'b1000000, 8); blank(2);
        hold(4'b1101, 7'b0010010, 8); blank(2);
        hold(4'b1011, 7'b1000110, 8); blank(2);
        hold(4'b0111, 7'b0000110, 8); blank(4);
        chk("post_rst_digits", 32'(digits), 32'hEC50);
        chk("post_rst_frames", 32'(fv_count - fv_base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
